split_gen_54: RTL
=================

# split_gen_54

Sequential assignment generator for split constraint 54, the driving end of that constraint's check (x = 1 iff var_124 == 0). On `start` it enumerates every value of the WIDTH-bit variable `var_124` exactly once over a valid/ready stream and tags each beat with the constraint result. It also counts satisfying assignments, so the solver bench can cross-check the BDD model's solution count.

## Interface
- WIDTH, 7, width of the enumerated variable `var_124`; legal range 3..8.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  begin a sweep; sampled only in IDLE.
- busy  out  1  high in EMIT and DONE.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts the beat.
- var_124  out  WIDTH  current candidate assignment.
- x  out  1  constraint result for `var_124`: (var_124 == 0).
- out_last  out  1  final beat of the sweep.
- done  out  1  one-cycle pulse after the last beat is accepted.
- sat_count  out  WIDTH+1  number of accepted beats with x = 1 in the current or last sweep.

## Operation
- State machine: IDLE, EMIT, DONE.
- IDLE:
  - out_valid = 0, var_124 = 0, out_last = 0.
  - `start` = 1 -> EMIT, candidate = 0, sat_count cleared.
- EMIT:
  - out_valid = 1.
  - Beat accepted on out_valid & out_ready. The candidate advances to the next value on the following edge.
  - Accept of the out_last beat -> DONE.
- DONE: done = 1 for exactly one cycle, then -> IDLE.
- Default order is linear: 0, 1, …, 2^WIDTH−1. out_last is asserted on 2^WIDTH−1.
- x is combinational from the registered candidate: x = ~|var_124.
- sat_count adds 1 on each accepted beat with x = 1. It is held after DONE until the next accepted `start`. Width WIDTH+1 means it cannot overflow.
- `start` in EMIT or DONE is ignored; no restart and no queueing.
- While out_ready = 0 in EMIT:
  - var_124, x and out_last hold stable.
  - out_valid stays high; it is never withdrawn.
- rst at any time, including mid-sweep:
  - Next edge -> IDLE.
  - All outputs return to reset values.
  - The partial sweep is abandoned and sat_count = 0.

## Timing
- Reset values: busy 0, out_valid 0, var_124 0, x 1 (var_124 = 0; not qualified by valid), out_last 0, done 0, sat_count 0.
- `start` at edge N -> out_valid = 1 with var_124 = 0 from cycle N+1.
- With out_ready held high, one beat per cycle. A full sweep takes 2^WIDTH cycles of EMIT, then 1 cycle of DONE.
- Last accept at edge M:
  - done = 1 and out_valid = 0 during cycle M+1.
  - IDLE from M+2.
  - Earliest next `start` is sampled at edge M+2.
- sat_count is registered and reflects an accepted beat one cycle after the accepting edge.

## Configuration
- Macro: `SPLIT_GEN_LFSR_EN`.
- Undefined: linear order as above.
- Defined: scrambled order.
  - First beat is 0, then a maximal-length Fibonacci LFSR seeded with 1.
  - Update: next = {s[WIDTH−2:0], fb}, where fb is the XOR of the tap bits.
  - Taps (1-based bit positions, x^n terms): W3 {3,2}; W4 {4,3}; W5 {5,3}; W6 {6,5}; W7 {7,6}; W8 {8,6,5,4}.
  - out_last is asserted on 1 followed by WIDTH−1 zeros (0x40 for WIDTH = 7), the predecessor of the seed.
  - Beat count is still 2^WIDTH, with every value appearing exactly once.
- All handshake, count and timing rules are identical in both modes.

## Test plan
- Linear sweep, WIDTH = 7, out_ready = 1:
  - start -> 128 beats with var_124 0x00..0x7F.
  - x = 1 only on the first beat; out_last only on 0x7F.
  - done pulse 1 cycle later; sat_count = 1.
- Backpressure: out_ready toggling 1,0,0,1 throughout -> no value skipped or duplicated; var_124 stable during stalls; still 128 beats; sat_count = 1.
- Reset mid-sweep: rst after 40 accepts -> next cycle out_valid = 0, busy = 0, sat_count = 0. A new start restarts at 0x00.
- Start while busy: start pulses during EMIT and DONE -> no effect; exactly one sweep and one done.
- `SPLIT_GEN_LFSR_EN` build, WIDTH = 7:
  - Sequence begins 0x00, 0x01, 0x02, 0x04, and ends at 0x40 with out_last.
  - All 128 values are distinct; sat_count = 1.
- WIDTH = 3: sweep yields 8 beats; sat_count = 1; done timing as specified.

Source files
------------

// File: rtl/split_gen_54.sv
// Sequential assignment generator for split constraint 54 (x = 1 iff var_124 == 0).
// Define SPLIT_GEN_LFSR_EN for the scrambled (0 then maximal-length LFSR) sweep order.
module split_gen_54 #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] var_124,
  output logic             x,
  output logic             out_last,
  output logic             done,
  output logic [WIDTH:0]   sat_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;

`ifdef SPLIT_GEN_LFSR_EN
  function automatic logic [7:0] tap_mask(input int w);
    case (w)
      3:       tap_mask = 8'h06;
      4:       tap_mask = 8'h0C;
      5:       tap_mask = 8'h14;
      6:       tap_mask = 8'h30;
      7:       tap_mask = 8'h60;
      8:       tap_mask = 8'hB8;
      default: tap_mask = 8'h00;
    endcase
  endfunction

  localparam logic [7:0]       TAPS8    = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS8[WIDTH-1:0];
  // The LFSR state preceding the seed closes the cycle, so it is the final beat.
  localparam logic [WIDTH-1:0] LAST_VAL = {1'b1, {(WIDTH-1){1'b0}}};
`else
  localparam logic [WIDTH-1:0] LAST_VAL = '1;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH:0]   sat_q, sat_d;
  logic [WIDTH-1:0] cand_next;
  logic             accept;
  logic             is_last;

  assign accept  = (state_q == EMIT) && out_ready;
  assign is_last = (cand_q == LAST_VAL);

`ifdef SPLIT_GEN_LFSR_EN
  // Zero is outside the LFSR cycle, so it is emitted once and then jumps to the seed.
  always_comb begin
    if (cand_q == '0) begin
      cand_next = {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cand_next = {cand_q[WIDTH-2:0], ^(cand_q & TAPS)};
    end
  end
`else
  assign cand_next = cand_q + {{(WIDTH-1){1'b0}}, 1'b1};
`endif

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EMIT;
          cand_d  = '0;
          sat_d   = '0;
        end
      end
      EMIT: begin
        if (accept) begin
          sat_d = sat_q + {{WIDTH{1'b0}}, x};
          if (is_last) begin
            state_d = DONE;
            cand_d  = '0;
          end else begin
            cand_d = cand_next;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cand_d  = '0;
        sat_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= '0;
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      sat_q   <= sat_d;
    end
  end

  // cand_q is forced to zero outside EMIT, so var_124 and x need no extra gating.
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == EMIT);
  assign var_124   = cand_q;
  assign x         = ~|cand_q;
  assign out_last  = (state_q == EMIT) && is_last;
  assign done      = (state_q == DONE);
  assign sat_count = sat_q;

endmodule
